// File: rtl/cpu_pkg.sv
// Shared CPU types for the decode stage: opcodes, ALU/control op enums,
// immediate formats and the decoded control bundle.
package cpu_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [4:0] {
    CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
    CU_SB, CU_SH, CU_SW, CU_ALU
  } cu_op_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  typedef struct packed {
    cu_op_t     cu_op;
    alu_op_t    alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       mem_to_reg;
    logic       illegal;
    logic       uses_rs1;
    logic       uses_rs2;
  } decoded_t;

  // Every immediate format draws only on instr[31:7]; result is sign-extended to 32.
  function automatic logic [31:0] imm32(input logic [31:7] ins, input imm_fmt_t fmt);
    case (fmt)
      IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm32 = {ins[31:12], 12'b0};
      IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I (+ optional M) decoder: raw instruction word to control
// bundle and sign-extended immediate.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]     instr,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       sll_bad, sr_bad;
  imm_fmt_t   fmt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // RV64 shifts borrow instr[25] as shamt[5]
  assign sll_bad = (XLEN == 32) ? (instr[31:25] != '0) : (instr[31:26] != '0);
  assign sr_bad  = (XLEN == 32) ? ({instr[31], instr[29:25]} != '0)
                                : ({instr[31], instr[29:26]} != '0);

  always_comb begin
    dec        = '0;
    dec.cu_op  = CU_ALU;
    dec.alu_op = ALU_ADD;
    fmt        = IMM_NONE;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        dec.cu_op     = (opcode == OP_LUI) ? CU_LUI : CU_AUIPC;
        fmt           = IMM_U;
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_JAL: begin
        dec.cu_op     = CU_JAL;
        fmt           = IMM_J;
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec.cu_op     = CU_JALR;
        fmt           = IMM_I;
        dec.rs1       = instr[19:15];
        dec.uses_rs1  = 1'b1;
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.illegal   = (f3 != 3'b000);
      end
      OP_BTYPE: begin
        fmt          = IMM_B;
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.branch   = 1'b1;
        dec.alu_op   = ALU_SUB;
        case (f3)
          3'b000:  dec.cu_op = CU_BEQ;
          3'b001:  dec.cu_op = CU_BNE;
          3'b100:  dec.cu_op = CU_BLT;
          3'b101:  dec.cu_op = CU_BGE;
          3'b110:  dec.cu_op = CU_BLTU;
          3'b111:  dec.cu_op = CU_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        fmt            = IMM_I;
        dec.rs1        = instr[19:15];
        dec.uses_rs1   = 1'b1;
        dec.rd         = instr[11:7];
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        case (f3)
          3'b000:  dec.cu_op = CU_LB;
          3'b001:  dec.cu_op = CU_LH;
          3'b010:  dec.cu_op = CU_LW;
          3'b100:  dec.cu_op = CU_LBU;
          3'b101:  dec.cu_op = CU_LHU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        fmt           = IMM_S;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        case (f3)
          3'b000:  dec.cu_op = CU_SB;
          3'b001:  dec.cu_op = CU_SH;
          3'b010:  dec.cu_op = CU_SW;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ITYPE: begin
        fmt           = IMM_I;
        dec.rs1       = instr[19:15];
        dec.uses_rs1  = 1'b1;
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = ALU_ADD;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b110:  dec.alu_op = ALU_OR;
          3'b111:  dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op  = ALU_SLL;
            dec.illegal = sll_bad;
          end
          default: begin
            dec.alu_op  = instr[30] ? ALU_SRA : ALU_SRL;
            dec.illegal = sr_bad;
          end
        endcase
      end
      OP_RTYPE: begin
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        case (f7)
          F7_BASE:
            case (f3)
              3'b000:  dec.alu_op = ALU_ADD;
              3'b001:  dec.alu_op = ALU_SLL;
              3'b010:  dec.alu_op = ALU_SLT;
              3'b011:  dec.alu_op = ALU_SLTU;
              3'b100:  dec.alu_op = ALU_XOR;
              3'b101:  dec.alu_op = ALU_SRL;
              3'b110:  dec.alu_op = ALU_OR;
              default: dec.alu_op = ALU_AND;
            endcase
          F7_ALT:
            case (f3)
              3'b000:  dec.alu_op = ALU_SUB;
              3'b101:  dec.alu_op = ALU_SRA;
              default: dec.illegal = 1'b1;
            endcase
          F7_MULDIV:
            if (ENABLE_M) begin
              case (f3)
                3'b000:  dec.alu_op = ALU_MUL;
                3'b001:  dec.alu_op = ALU_MULH;
                3'b010:  dec.alu_op = ALU_MULHSU;
                3'b011:  dec.alu_op = ALU_MULHU;
                3'b100:  dec.alu_op = ALU_DIV;
                3'b101:  dec.alu_op = ALU_DIVU;
                3'b110:  dec.alu_op = ALU_REM;
                default: dec.alu_op = ALU_REMU;
              endcase
            end else begin
              dec.illegal = 1'b1;
            end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal ops still flow to EX for trapping, but must have no side effects
    if (dec.illegal) begin
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.branch     = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.uses_rs1   = 1'b0;
      dec.uses_rs2   = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;

    imm = XLEN'($signed(imm32(instr[31:7], fmt)));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between IF and EX: 2-entry skid buffer of decoded
// bundles, load-use bubble insertion and flush.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_pc,
  output cu_op_t            id_cu_op,
  output alu_op_t           id_alu_op,
  output logic [XLEN-1:0]   id_imm,
  output logic [REG_AW-1:0] id_rs1,
  output logic [REG_AW-1:0] id_rs2,
  output logic [REG_AW-1:0] id_rd,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_branch,
  output logic              id_alu_src,
  output logic              id_mem_to_reg,
  output logic              id_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

  buf_state_t      state, state_nxt;
  decoded_t        dec, out_q, skid_q;
  logic [XLEN-1:0] dec_imm, out_imm, skid_imm, out_pc, skid_pc;
  logic            ld_vld, hazard, if_xfer, ex_xfer;
  logic [4:0]      ld_rd;
  logic            take_dec, take_skid, fill_skid;

  instr_decoder #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_dec (
    .instr (if_instr),
    .dec   (dec),
    .imm   (dec_imm)
  );

  // ld_rd is never x0, so unused (zeroed) source fields can't match
  assign hazard = ld_vld && ((out_q.uses_rs1 && out_q.rs1 == ld_rd) ||
                             (out_q.uses_rs2 && out_q.rs2 == ld_rd));

  assign id_valid = (state != EMPTY) && !hazard;
  assign if_ready = (state != TWO);
  assign if_xfer  = if_valid && if_ready;
  assign ex_xfer  = id_valid && ex_ready;

  always_comb begin
    state_nxt = state;
    take_dec  = 1'b0;
    take_skid = 1'b0;
    fill_skid = 1'b0;
    case (state)
      EMPTY:
        if (if_xfer) begin
          state_nxt = ONE;
          take_dec  = 1'b1;
        end
      ONE:
        if (if_xfer && ex_xfer) begin
          take_dec = 1'b1;
        end else if (if_xfer) begin
          state_nxt = TWO;
          fill_skid = 1'b1;
        end else if (ex_xfer) begin
          state_nxt = EMPTY;
        end
      TWO:
        if (ex_xfer) begin
          state_nxt = ONE;
          take_skid = 1'b1;
        end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      take_dec  = 1'b0;
      take_skid = 1'b0;
      fill_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_q    <= '0;
      out_imm  <= '0;
      out_pc   <= '0;
      skid_q   <= '0;
      skid_imm <= '0;
      skid_pc  <= '0;
      ld_vld   <= 1'b0;
      ld_rd    <= '0;
    end else begin
      state  <= state_nxt;
      // Load tracking lives exactly one cycle after the load leaves
      ld_vld <= !flush && ex_xfer && out_q.mem_read && (out_q.rd != 5'd0);
      if (ex_xfer) ld_rd <= out_q.rd;
      if (take_dec) begin
        out_q   <= dec;
        out_imm <= dec_imm;
        out_pc  <= if_pc;
      end else if (take_skid) begin
        out_q   <= skid_q;
        out_imm <= skid_imm;
        out_pc  <= skid_pc;
      end
      if (fill_skid) begin
        skid_q   <= dec;
        skid_imm <= dec_imm;
        skid_pc  <= if_pc;
      end
    end
  end

  assign id_pc         = out_pc;
  assign id_cu_op      = out_q.cu_op;
  assign id_alu_op     = out_q.alu_op;
  assign id_imm        = out_imm;
  assign id_rs1        = REG_AW'(out_q.rs1);
  assign id_rs2        = REG_AW'(out_q.rs2);
  assign id_rd         = REG_AW'(out_q.rd);
  assign id_reg_write  = out_q.reg_write;
  assign id_mem_read   = out_q.mem_read;
  assign id_mem_write  = out_q.mem_write;
  assign id_branch     = out_q.branch;
  assign id_alu_src    = out_q.alu_src;
  assign id_mem_to_reg = out_q.mem_to_reg;
  assign id_illegal    = out_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage, successor to the combinational control unit; sits between fetch (IF) and execute (EX).
- Decodes every RV32I format, with the M extension optional, into the existing control-signal set.
- Generates sign-extended XLEN immediates, holds a 2-entry skid buffer with valid/ready handshakes on both sides, inserts load-use bubbles and supports flush.

Parameters:
XLEN, 32, datapath/PC/immediate width (32 or 64)
ENABLE_M, 0, 1 = decode M-extension ops; 0 = M encodings flagged illegal
REG_AW, 5, register-index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  IF presents an instruction
if_ready  out  1  stage can accept an instruction this cycle
if_instr  in  32  raw instruction word
if_pc  in  XLEN  PC of if_instr
flush  in  1  squash all held instructions (branch mispredict/trap)
ex_ready  in  1  EX accepts the id_* bundle this cycle
id_valid  out  1  id_* bundle valid
id_pc  out  XLEN  PC of decoded instruction
id_cu_op  out  cu_op_t  control op (LUI, AUIPC, JAL, JALR, BEQ..BGEU, LB..LHU, SB..SW, ALU)
id_alu_op  out  alu_op_t  ALU function
id_imm  out  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  out  REG_AW each  register indices (0 when unused by format)
id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_src, id_mem_to_reg  out  1 each  control strobes
id_illegal  out  1  unsupported opcode/funct encoding

Behaviour:
- Reset: buffer EMPTY, id_valid=0, if_ready=1, all id_* bundle fields 0, load-tracking cleared. Applies asynchronously, including mid-transfer; in-flight instructions are dropped.
- Transfer rules: IF transfer = if_valid&if_ready; EX transfer = id_valid&ex_ready. The id_* bundle is held stable while id_valid&!ex_ready.
- Latency: 1 cycle IF transfer to id_valid when EMPTY; throughput 1 instr/cycle when ex_ready stays high.
- Buffer FSM:
  - EMPTY -(IF)-> ONE.
  - ONE -(IF & !EX)-> TWO; ONE -(EX & !IF)-> EMPTY; ONE -(IF & EX)-> ONE.
  - TWO -(EX)-> ONE, skid entry moves to output.
- if_ready = (state != TWO), registered; no combinational path from ex_ready.
- Decode is done before the buffer (instr_decoder output registered), so the skid entry stores decoded fields.
- Immediates:
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All sign-extended from instr[31] to XLEN.
- Control strobes:
  - ITYPE: reg_write=1, alu_src=1, mem_write=0.
  - RTYPE: reg_write=1, alu_src=0.
  - LOAD: mem_read=1, mem_to_reg=1.
  - STORE: mem_write=1, alu_src=1, rd=0.
  - BTYPE: branch=1, ALU_SUB.
  - SRAI/SRA selected by instr[30].
- M extension: opcode RTYPE with funct7=0000001 selects ALU_MUL..ALU_REMU when ENABLE_M=1; otherwise id_illegal=1.
- Illegal encodings: unknown opcode/funct → id_illegal=1 with all write/mem/branch strobes 0. The instruction still flows with id_valid=1 so EX can trap.
- rd=x0 forces id_reg_write=0.
- Load-use interlock:
  - On an EX transfer of a load with rd≠0, record rd for one cycle.
  - If the next output-entry instruction reads that rd (rs1 or rs2 used by its format), hold id_valid=0 for exactly one cycle (bubble), then present it.
  - Entries stay buffered during the bubble; if_ready follows the FSM.
- Flush: synchronous. Next cycle state=EMPTY, id_valid=0, load-tracking cleared, if_ready=1. Any IF transfer in the flush cycle is discarded. Flush overrides a simultaneous EX transfer (the bundle counts as consumed only if ex_ready was high that cycle).

Decomposition:
- cpu_pkg additions:
  - opcode constants: LUI, AUIPC, JAL, JALR, BTYPE, LOAD, STORE, ITYPE, RTYPE.
  - alu_op_t extended with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - cu_op_t with an ALU member.
  - imm_fmt_t (I, S, B, U, J, NONE).
  - packed decoded_t bundle struct.
- One sub-module: instr_decoder (combinational, parametrised XLEN/ENABLE_M, instr → decoded_t). decode_stage instantiates it and owns the FSM, skid buffer and interlock.

Test Plan:
- Reset then 0xFFF00093 (addi x1,x0,-1) → next cycle id_valid=1, id_imm=0xFFFFFFFF, rd=1, rs1=0, ALU_ADD, alu_src=1, reg_write=1, mem_write=0.
- 0xFE000EE3 (beq x0,x0,-4) → id_branch=1, id_cu_op=BEQ, id_imm=0xFFFFFFFC, reg_write=0.
- 0x00012283 (lw x5,0(x2)) then 0x00128333 (add x6,x5,x1), ex_ready=1 → lw issued, exactly one id_valid=0 cycle, then add issued with rs1=5, rs2=1. Repeat with add x6,x4,x1 → no bubble.
- Stream 4 instrs, ex_ready=0 for 3 cycles → if_ready falls after 2 accepted. Bundle is stable while stalled. On release all 4 emerge in order, none lost or duplicated.
- Flush asserted with state TWO → next cycle id_valid=0, if_ready=1. Next accepted instruction appears 1 cycle later with its own PC.
- 0x022081B3 (mul x3,x1,x2): ENABLE_M=0 → id_illegal=1, reg_write=0. ENABLE_M=1 → ALU_MUL, reg_write=1. 0x00000000 → id_illegal=1.
